// File: rtl/counter_sequence_monitor.sv
// counter_sequence_monitor: locks onto a clean +1 count run, then flags bad steps, counts errors and pulses on wraps.
module counter_sequence_monitor #(
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_WIDTH-1:0] err_count
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam logic [1:0] ACQUIRE = 2'd0;
  localparam logic [1:0] TRACK   = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [RW-1:0]        run_q, run_d, run_inc;
  logic [ERR_WIDTH-1:0] err_q, err_d, err_sat;
  logic                 errp_q, errp_d, wrapp_q, wrapp_d;
  logic                 good;
  assign good    = q_in == prev_q + WIDTH'(1);
  assign run_inc = run_q + RW'(1);
  assign err_sat = &err_q ? err_q : err_q + ERR_WIDTH'(1);
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    err_d   = err_q;
    errp_d  = 1'b0;
    wrapp_d = 1'b0;
    if (en) begin
      prev_d = q_in;
      if (state_q == TRACK) begin
        run_d   = good ? run_inc : '0;
        state_d = good && run_inc == RW'(LOCK_COUNT) ? LOCKED : TRACK;
      end else if (state_q == LOCKED) begin
        wrapp_d = good && &prev_q;
        errp_d  = !good;
        err_d   = good ? err_q : err_sat;
        run_d   = good ? run_q : '0;
        state_d = good ? LOCKED : TRACK;
      end else begin
        run_d   = '0;
        state_d = TRACK;
      end
    end
    // clear wins over a coincident increment; err_pulse is unaffected
    if (clear_err) err_d = '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACQUIRE;
      prev_q  <= '0;
      run_q   <= '0;
      err_q   <= '0;
      errp_q  <= 1'b0;
      wrapp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      err_q   <= err_d;
      errp_q  <= errp_d;
      wrapp_q <= wrapp_d;
    end
  end
  assign locked     = state_q == LOCKED;
  assign err_pulse  = errp_q;
  assign wrap_pulse = wrapp_q;
  assign err_count  = err_q;
endmodule

// File: tb/tb_counter_sequence_monitor.sv
// tb_counter_sequence_monitor: directed and random stimulus against a step-rule model; a second instance checks 2-bit saturation.
module tb_counter_sequence_monitor;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] q_in = '0;
  logic       clear_err = 1'b0;
  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count;
  logic       s_locked, s_err_pulse, s_wrap_pulse;
  logic [1:0] s_err_count;
  int total = 0, bad = 0;
  int m_prev, m_run, m_cnt8, m_cnt2, cq;
  bit m_acq, m_lock, m_ep, m_wp;
  always #5 clk = ~clk;
  counter_sequence_monitor dut (
    .clk(clk), .reset_n(reset_n), .en(en), .q_in(q_in), .clear_err(clear_err),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .err_count(err_count)
  );
  counter_sequence_monitor #(.ERR_WIDTH(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .en(en), .q_in(q_in), .clear_err(clear_err),
    .locked(s_locked), .err_pulse(s_err_pulse), .wrap_pulse(s_wrap_pulse), .err_count(s_err_count)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_prev = 0; m_run = 0; m_cnt8 = 0; m_cnt2 = 0;
    m_acq = 0; m_lock = 0; m_ep = 0; m_wp = 0;
  endtask
  task automatic check_all();
    chk("locked", locked, m_lock);
    chk("err_pulse", err_pulse, m_ep);
    chk("wrap_pulse", wrap_pulse, m_wp);
    chk("err_count", err_count, m_cnt8);
    chk("s_locked", s_locked, m_lock);
    chk("s_err_count", s_err_count, m_cnt2);
  endtask
  task automatic tick(input bit e, input int q, input bit clr);
    bit good;
    en = e; q_in = 3'(q); clear_err = clr;
    @(posedge clk);
    m_ep = 0; m_wp = 0;
    if (e) begin
      good = q == (m_prev + 1) % 8;
      if (!m_acq) begin
        m_acq = 1; m_run = 0;
      end else if (!m_lock) begin
        m_run = good ? m_run + 1 : 0;
        if (m_run == 4) m_lock = 1;
      end else if (good) begin
        m_wp = m_prev == 7;
      end else begin
        m_ep = 1; m_lock = 0; m_run = 0;
        m_cnt8 = m_cnt8 < 255 ? m_cnt8 + 1 : 255;
        m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
      end
      m_prev = q;
    end
    if (clr) begin m_cnt8 = 0; m_cnt2 = 0; end
    if (e) cq = q;
    #1 check_all();
  endtask
  task automatic count(input int n);
    for (int i = 0; i < n; i++) tick(1, (cq + 1) % 8, 0);
  endtask
  task automatic count_to(input int v);
    for (int i = 0; i < 8 && cq != v; i++) tick(1, (cq + 1) % 8, 0);
  endtask
  initial begin
    model_reset();
    cq = 7;
    #12 check_all();
    chk("rst_locked", locked, 0);
    @(negedge clk) reset_n = 1'b1;
    // free run from 0: lock after 5th edge, wraps every 8
    count(24);
    count_to(3);
    tick(1, 5, 0);
    chk("jump_err", err_pulse, 1);
    count(4);
    chk("relock", locked, 1);
    count_to(2);
    tick(1, 2, 0); tick(1, 2, 0); tick(1, 2, 0);
    count(6);
    for (int k = 0; k < 5; k++) begin
      tick(1, (cq + 3) % 8, 0);
      count(4);
    end
    chk("sat2", s_err_count, 3);
    tick(1, (cq + 2) % 8, 1);
    chk("clr_pulse", err_pulse, 1);
    chk("clr_count", err_count, 0);
    count(4);
    count_to(4);
    tick(0, 1, 0); tick(0, 6, 0);
    chk("en0_locked", locked, 1);
    tick(1, 6, 0);
    chk("en0_err", err_pulse, 1);
    for (int i = 0; i < 400; i++) begin
      int r, q;
      r = $urandom_range(0, 99);
      q = r < 8 ? $urandom_range(0, 7) : (cq + 1) % 8;
      tick($urandom_range(0, 9) != 0, q, $urandom_range(0, 49) == 0);
    end
    count(6);
    tick(1, (cq + 5) % 8, 0);
    count(5);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_locked", locked, 0);
    chk("async_count", err_count, 0);
    #1 reset_n = 1'b1;
    cq = 7;
    tick(1, 3, 0);
    count(5);
    chk("post_rst_lock", locked, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
